// File: rtl/conv_stream_fifo_if.sv
// Handshake bundle between a conv layer's feature-map FIFO and its neighbours.
// The write side carries the upstream layer's output stream and back-pressure.
// The read side carries the downstream conv's read request and returned data.
interface conv_stream_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNEL    = 4,
    parameter int DEPTH      = 16
);
    localparam int W  = DATA_WIDTH * CHANNEL;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  i_data;
    logic          i_valid;
    logic          almost_full;
    logic          fifo_rd_en;
    logic [W-1:0]  o_data;
    logic          o_valid;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;

    // Environment side: drives writes and read requests, observes status.
    modport master (
        output i_data, i_valid, fifo_rd_en,
        input  almost_full, o_data, o_valid, empty, count, overflow
    );

    // FIFO side: accepts writes and read requests, reports data and status.
    modport slave (
        input  i_data, i_valid, fifo_rd_en,
        output almost_full, o_data, o_valid, empty, count, overflow
    );
endinterface

// File: rtl/conv_stream_fifo.sv
// Channel-packed stream FIFO feeding a conv layer's feature-map input.
// Writes come from the previous layer's output stream and are throttled with
// almost_full; reads return one stored word a cycle after each accepted request.
module conv_stream_fifo #(
    parameter int DATA_WIDTH         = 8,
    parameter int CHANNEL            = 4,
    parameter int DEPTH              = 16,
    parameter int ALMOST_FULL_MARGIN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    conv_stream_fifo_if.slave   bus
);
    localparam int W  = DATA_WIDTH * CHANNEL;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - ALMOST_FULL_MARGIN);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;
    logic [W-1:0]  o_data_q;
    logic          o_valid_q;
    logic          overflow_q;
    logic          almost_full_q;
    logic          rd_acc;
    logic          wr_acc;
    logic          drop;

    // Accept decisions: a read needs stored data (no fall-through from a
    // same-cycle write); a write into a full FIFO is fine if a read frees a slot.
    always_comb begin
        rd_acc = bus.fifo_rd_en && (count_q != '0);
        wr_acc = bus.i_valid && ((count_q != FULL_LEVEL) || rd_acc);
        drop   = bus.i_valid && !wr_acc;
    end

    // Occupancy for the next cycle; a simultaneous read and write cancel out.
    always_comb begin
        count_next = count_q;
        if (wr_acc && !rd_acc) begin
            count_next = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count_q - CW'(1);
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.i_data;
        end
    end

    // Pointers, occupancy, registered read port and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            o_data_q      <= '0;
            o_valid_q     <= 1'b0;
            overflow_q    <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            count_q       <= count_next;
            almost_full_q <= (count_next >= AF_LEVEL);
            o_valid_q     <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + AW'(1);
                o_data_q <= mem[rd_ptr];
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Status outputs come straight from the registers, with no added latency.
    always_comb begin
        bus.o_data      = o_data_q;
        bus.o_valid     = o_valid_q;
        bus.count       = count_q;
        bus.empty       = (count_q == '0);
        bus.overflow    = overflow_q;
        bus.almost_full = almost_full_q;
    end
endmodule

// File: tb/tb_conv_stream_fifo.sv
// Self-checking bench for conv_stream_fifo: directed scenarios plus random
// traffic, scored against a queue-based reference model of the FIFO.
module tb_conv_stream_fifo;
    localparam int DATA_WIDTH = 8;
    localparam int CHANNEL    = 4;
    localparam int DEPTH      = 16;
    localparam int MARGIN     = 4;
    localparam int W          = DATA_WIDTH * CHANNEL;

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [W-1:0] model_q [$];
    exp_t         exp_q [$];
    logic         ovf_m     = 1'b0;
    logic [W-1:0] last_data = '0;

    conv_stream_fifo_if #(
        .DATA_WIDTH (DATA_WIDTH),
        .CHANNEL    (CHANNEL),
        .DEPTH      (DEPTH)
    ) bus ();

    conv_stream_fifo #(
        .DATA_WIDTH         (DATA_WIDTH),
        .CHANNEL            (CHANNEL),
        .DEPTH              (DEPTH),
        .ALMOST_FULL_MARGIN (MARGIN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock and cycle counter used to time expected read data.
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        ovf_m     = 1'b0;
        last_data = '0;
    endtask

    // Drive one cycle of inputs and advance the reference model by the FIFO rules.
    task automatic apply_stimulus(input logic wv, input logic [W-1:0] wd, input logic re);
        logic ra;
        logic wa;
        exp_t e;
        bus.i_valid    = wv;
        bus.i_data     = wd;
        bus.fifo_rd_en = re;
        ra = re && (model_q.size() != 0);
        wa = wv && ((model_q.size() != DEPTH) || ra);
        if (ra) begin
            e.data = model_q.pop_front();
            e.due  = cyc + 1;
            exp_q.push_back(e);
        end
        if (wa) model_q.push_back(wd);
        if (wv && !wa) ovf_m = 1'b1;
    endtask

    // Let the edge happen, then compare status outputs against the model.
    task automatic check_output();
        @(posedge clk);
        #1;
        check("count", 64'(bus.count), 64'(model_q.size()));
        check("empty", 64'(bus.empty), 64'(model_q.size() == 0));
        check("almost_full", 64'(bus.almost_full), 64'(model_q.size() >= DEPTH - MARGIN));
        check("overflow", 64'(bus.overflow), 64'(ovf_m));
    endtask

    task automatic cycle(input logic wv, input logic [W-1:0] wd, input logic re);
        apply_stimulus(wv, wd, re);
        check_output();
    endtask

    // Called one time unit after a rising edge; asserts reset between edges.
    task automatic pulse_reset();
        #1;
        rst_n = 1'b0;
        model_reset();
        bus.i_valid    = 1'b0;
        bus.i_data     = '0;
        bus.fifo_rd_en = 1'b0;
        #1;
        check("rst_o_valid", 64'(bus.o_valid), 64'(0));
        check("rst_o_data", 64'(bus.o_data), 64'(0));
        check("rst_count", 64'(bus.count), 64'(0));
        check("rst_empty", 64'(bus.empty), 64'(1));
        check("rst_almost_full", 64'(bus.almost_full), 64'(0));
        check("rst_overflow", 64'(bus.overflow), 64'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Read-port monitor: each expected word must appear exactly on its due
    // cycle; otherwise o_valid stays low and o_data holds its last value.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                check("o_valid_read", 64'(bus.o_valid), 64'(1));
                check("o_data_read", 64'(bus.o_data), 64'(e.data));
                last_data = e.data;
            end else begin
                check("o_valid_idle", 64'(bus.o_valid), 64'(0));
                check("o_data_hold", 64'(bus.o_data), 64'(last_data));
            end
        end
    end

    // Hard stop in case a scenario stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] word;
        bus.i_valid    = 1'b0;
        bus.i_data     = '0;
        bus.fifo_rd_en = 1'b0;
        @(posedge clk);
        #1;
        pulse_reset();

        // Fill to full, then one write too many.
        for (int i = 0; i < DEPTH; i++) begin
            word = 32'h0403_0201 + W'(i);
            cycle(1'b1, word, 1'b0);
        end
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0);

        // Drain everything in write order.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Read on empty with a same-cycle write, then read that word.
        cycle(1'b1, 32'h1234_5678, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Full FIFO with a simultaneous read and write.
        pulse_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h1000_0000 + W'(i), 1'b0);
        cycle(1'b1, 32'hAABB_CCDD, 1'b1);
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Continuous streaming across many pointer wraps.
        for (int i = 0; i < 40; i++) cycle(1'b1, 32'h5000_0000 + W'(i), 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Random traffic with different write/read balances.
        for (int phase = 0; phase < 4; phase++) begin
            int pw;
            int pr;
            pw = (phase == 0) ? 80 : (phase == 1) ? 30 : (phase == 2) ? 60 : 95;
            pr = (phase == 0) ? 30 : (phase == 1) ? 80 : (phase == 2) ? 60 : 50;
            for (int i = 0; i < 80; i++) begin
                cycle(logic'($urandom_range(0, 99) < pw), W'($urandom()),
                      logic'($urandom_range(0, 99) < pr));
            end
        end
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Asynchronous reset with data stored and a read in flight.
        pulse_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, 32'h7000_0000 + W'(i), 1'b0);
        apply_stimulus(1'b0, '0, 1'b1);
        @(posedge clk);
        #1;
        pulse_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
